keypad_conditioner: RTL and testbench
=====================================

Name: keypad_conditioner

Overview:
- Front-end conditioner for the nap machine's raw 10-key pad and '#' key.
- Synchronises and debounces the raw lines, and rejects multi-key chords.
- Emits clean one-hot level outputs for the machine's `keypad[9:0]` and `sharp` inputs, plus a BCD key code with a one-cycle strobe for future consumers.
- Sits directly upstream of the nap machine top level, between the board pins and the machine.

Parameters:
- DEBOUNCE_CNT, 20000: consecutive stable clock cycles required before accepting a press or a release (minimum 2).
- CNT_W, 16: width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CNT.

Ports:
- clock  input  1  system clock, same clock as the nap machine.
- reset  input  1  asynchronous, active-low reset.
- key_raw  input  10  raw keypad lines; bit i = digit i, 1 = pressed.
- sharp_raw  input  1  raw '#' line, 1 = pressed.
- keypad  output  10  debounced one-hot digit level, held while the key is accepted.
- sharp  output  1  debounced '#' level, held while accepted.
- key_code  output  4  0-9 = digit, 10 = '#', 15 = none.
- key_valid  output  1  one-cycle pulse on acceptance of a press.
- key_error  output  1  one-cycle pulse when a stable multi-key chord is rejected.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset asserted (low) asynchronously forces: keypad=0, sharp=0, key_code=15, key_valid=0, key_error=0, FSM=IDLE, counter=0, synchroniser flops=0.
- Input path:
  - The 11-bit vector {sharp_raw, key_raw} passes through a 2-flop synchroniser to give `s`.
  - `s` is compared each cycle against the held register `smp`.
- Counter rule:
  - In CHECK, RELEASE and REJECT: if s != smp, then smp <= s and cnt <= 0; otherwise cnt increments.
  - Stability is reached when cnt == DEBOUNCE_CNT-1 with s == smp.
  - The counter saturates and never wraps.
- FSM states:
  - IDLE: outputs cleared. If s != 0, then smp <= s, cnt <= 0, go to CHECK.
  - CHECK: on stability:
    - popcount(smp)==1: latch outputs (keypad/sharp = smp, key_code = index), pulse key_valid, go to PRESSED.
    - popcount(smp)>=2: pulse key_error, go to REJECT.
    - smp==0: go to IDLE (glitch discarded, no pulse).
  - PRESSED: outputs held. If s != latched pattern, then smp <= s, cnt <= 0, go to RELEASE.
  - RELEASE: outputs remain held. On stability with smp==0: clear outputs (key_code=15), go to IDLE. On stability with smp != 0: stay, no new acceptance; the user must fully release first.
  - REJECT: outputs stay cleared. On stability with smp==0: go to IDLE.
- Latency:
  - Raw press held clean from edge t: key_valid and keypad are asserted after edge t+DEBOUNCE_CNT+2. This is 2 synchroniser edges plus DEBOUNCE_CNT counting edges, with the registered outputs updating on the final counting edge.
  - Release latency is the same.
- Output guarantees:
  - keypad and sharp are never both non-zero.
  - keypad is always one-hot or zero.
  - key_valid and key_error never assert in the same cycle.
  - Neither pulse lasts more than 1 cycle.
- Glitch handling:
  - A bounce shorter than DEBOUNCE_CNT restarts the count; no output change results.
- Roll-over: pressing a second key while one is held moves to RELEASE. The first key stays held until all keys are released; the second key is never accepted.
- Reset mid-operation: outputs clear immediately (asynchronously). After reset releases, a still-held key is re-accepted as a fresh press after the full latency.

Test Plan (DEBOUNCE_CNT=4):
1. Reset low then high, inputs idle → keypad=0, sharp=0, key_code=15, no pulses for 50 cycles.
2. key_raw=10'b0000100000 held 20 cycles, then 0 → key_valid 1-cycle pulse and keypad[5]=1, key_code=5, both at edge 6. Outputs cleared 6 edges after release.
3. key_raw[3] toggled every 2 cycles for 20 cycles, then 0 → no key_valid, keypad stays 0.
4. key_raw[1] and key_raw[7] asserted together for 20 cycles → one key_error pulse, keypad=0 throughout. After release, a key_raw[2] press yields key_code=2.
5. sharp_raw held 10 cycles → sharp=1, key_code=10, keypad=0. Then add key_raw[4] mid-hold → sharp stays 1 and no second key_valid until all lines are released.
6. key_raw[9] accepted, then reset pulsed low for 1 cycle while still held → outputs clear asynchronously, then key_valid re-pulses with key_code=9 after edge 6 post-reset.

Source files
------------

// File: rtl/keypad_conditioner_if.sv
// Signal bundle between the raw keypad pins, the conditioner and the nap machine.
// The conditioner takes the master side; the pad/machine side takes the slave side.
interface keypad_conditioner_if;
  logic [9:0] key_raw;
  logic       sharp_raw;
  logic [9:0] keypad;
  logic       sharp;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_error;

  modport master (
    input  key_raw,
    input  sharp_raw,
    output keypad,
    output sharp,
    output key_code,
    output key_valid,
    output key_error
  );

  modport slave (
    output key_raw,
    output sharp_raw,
    input  keypad,
    input  sharp,
    input  key_code,
    input  key_valid,
    input  key_error
  );
endinterface

// File: rtl/keypad_conditioner.sv
// Synchronises, debounces and chord-filters the raw 10-key pad plus '#' line,
// producing held one-hot levels, a BCD key code and one-cycle accept/reject pulses.
module keypad_conditioner #(
  parameter int DEBOUNCE_CNT = 20000,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  keypad_conditioner_if.master  kif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    PRESSED = 3'd2,
    RELEASE = 3'd3,
    REJECT  = 3'd4
  } state_t;

  // The load edge counts as the first counting edge, so the decision is taken on
  // the edge that moves the counter from DEBOUNCE_CNT-2 to DEBOUNCE_CNT-1.
  localparam logic [CNT_W-1:0] CNT_STABLE = CNT_W'(DEBOUNCE_CNT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

  function automatic logic [3:0] popcount11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 11; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] index11(input logic [10:0] v);
    logic [3:0] c;
    c = 4'd15;
    for (int i = 0; i < 11; i++) begin
      if (v[i]) begin
        c = 4'(i);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  state_t             state_r, state_s;
  logic [10:0]        sync1_r, s_r;
  logic [10:0]        smp_r, smp_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [9:0]         keypad_r, keypad_s;
  logic               sharp_r, sharp_s;
  logic [3:0]         key_code_r, key_code_s;
  logic               key_valid_r, key_valid_s;
  logic               key_error_r, key_error_s;

  logic               diff_s;
  logic               stable_s;
  logic [10:0]        smp_step_s;
  logic [CNT_W-1:0]   cnt_step_s;
  logic [3:0]         pop_s;

  // Two-flop synchroniser for the raw lines.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 11'd0;
      s_r     <= 11'd0;
    end else begin
      sync1_r <= {kif.sharp_raw, kif.key_raw};
      s_r     <= sync1_r;
    end
  end

  // State, debounce counter, sample register and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      smp_r       <= 11'd0;
      cnt_r       <= CNT_ZERO;
      keypad_r    <= 10'd0;
      sharp_r     <= 1'b0;
      key_code_r  <= 4'd15;
      key_valid_r <= 1'b0;
      key_error_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      smp_r       <= smp_s;
      cnt_r       <= cnt_s;
      keypad_r    <= keypad_s;
      sharp_r     <= sharp_s;
      key_code_r  <= key_code_s;
      key_valid_r <= key_valid_s;
      key_error_r <= key_error_s;
    end
  end

  // Shared restart-or-count step and the stability decision.
  always_comb begin
    diff_s     = (s_r != smp_r);
    stable_s   = (!diff_s) && (cnt_r == CNT_STABLE);
    pop_s      = popcount11(smp_r);
    smp_step_s = smp_r;
    cnt_step_s = cnt_r;
    if (diff_s) begin
      smp_step_s = s_r;
      cnt_step_s = CNT_ZERO;
    end else if (cnt_r != CNT_MAX) begin
      cnt_step_s = cnt_r + CNT_ONE;
    end else begin
      cnt_step_s = cnt_r;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s     = state_r;
    smp_s       = smp_r;
    cnt_s       = cnt_r;
    keypad_s    = keypad_r;
    sharp_s     = sharp_r;
    key_code_s  = key_code_r;
    key_valid_s = 1'b0;
    key_error_s = 1'b0;

    case (state_r)
      IDLE: begin
        keypad_s   = 10'd0;
        sharp_s    = 1'b0;
        key_code_s = 4'd15;
        if (s_r != 11'd0) begin
          smp_s   = s_r;
          cnt_s   = CNT_ZERO;
          state_s = CHECK;
        end else begin
          state_s = IDLE;
        end
      end

      CHECK: begin
        smp_s = smp_step_s;
        cnt_s = cnt_step_s;
        if (stable_s) begin
          if (pop_s == 4'd1) begin
            keypad_s    = smp_r[9:0];
            sharp_s     = smp_r[10];
            key_code_s  = index11(smp_r);
            key_valid_s = 1'b1;
            state_s     = PRESSED;
          end else if (pop_s >= 4'd2) begin
            key_error_s = 1'b1;
            state_s     = REJECT;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = CHECK;
        end
      end

      PRESSED: begin
        if (s_r != {sharp_r, keypad_r}) begin
          smp_s   = s_r;
          cnt_s   = CNT_ZERO;
          state_s = RELEASE;
        end else begin
          state_s = PRESSED;
        end
      end

      // A new stable non-zero pattern here is deliberately ignored: only a full
      // release returns to IDLE, which blocks roll-over acceptance.
      RELEASE: begin
        smp_s = smp_step_s;
        cnt_s = cnt_step_s;
        if (stable_s && (smp_r == 11'd0)) begin
          keypad_s   = 10'd0;
          sharp_s    = 1'b0;
          key_code_s = 4'd15;
          state_s    = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end

      REJECT: begin
        smp_s      = smp_step_s;
        cnt_s      = cnt_step_s;
        keypad_s   = 10'd0;
        sharp_s    = 1'b0;
        key_code_s = 4'd15;
        if (stable_s && (smp_r == 11'd0)) begin
          state_s = IDLE;
        end else begin
          state_s = REJECT;
        end
      end

      default: begin
        smp_s      = 11'd0;
        cnt_s      = CNT_ZERO;
        keypad_s   = 10'd0;
        sharp_s    = 1'b0;
        key_code_s = 4'd15;
        state_s    = IDLE;
      end
    endcase
  end

  assign kif.keypad    = keypad_r;
  assign kif.sharp     = sharp_r;
  assign kif.key_code  = key_code_r;
  assign kif.key_valid = key_valid_r;
  assign kif.key_error = key_error_r;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner with DEBOUNCE_CNT=4: press/release latency,
// bounce rejection, chord rejection, roll-over hold and mid-press reset.
module tb_keypad_conditioner;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   pulses;

  keypad_conditioner_if kif ();

  keypad_conditioner #(
    .DEBOUNCE_CNT (4),
    .CNT_W        (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .kif   (kif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_out(input string tag);
    chk({tag, "_keypad"}, {22'd0, kif.keypad}, 32'd0);
    chk({tag, "_sharp"}, {31'd0, kif.sharp}, 32'd0);
    chk({tag, "_code"}, {28'd0, kif.key_code}, 32'd15);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    kif.key_raw   = 10'd0;
    kif.sharp_raw = 1'b0;

    // 1: reset and idle
    repeat (3) tick();
    chk_idle_out("rst");
    chk("rst_valid", {31'd0, kif.key_valid}, 32'd0);
    chk("rst_error", {31'd0, kif.key_error}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("idle_valid", {31'd0, kif.key_valid}, 32'd0);
      chk("idle_error", {31'd0, kif.key_error}, 32'd0);
      chk("idle_keypad", {22'd0, kif.keypad}, 32'd0);
    end

    // 2: single clean press of digit 5
    kif.key_raw = 10'b0000100000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("k5_early_valid", {31'd0, kif.key_valid}, 32'd0);
      chk("k5_early_keypad", {22'd0, kif.keypad}, 32'd0);
    end
    tick();
    chk("k5_valid", {31'd0, kif.key_valid}, 32'd1);
    chk("k5_keypad", {22'd0, kif.keypad}, 32'h20);
    chk("k5_code", {28'd0, kif.key_code}, 32'd5);
    tick();
    chk("k5_pulse_end", {31'd0, kif.key_valid}, 32'd0);
    chk("k5_hold", {22'd0, kif.keypad}, 32'h20);
    repeat (13) tick();
    kif.key_raw = 10'd0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("k5_rel_hold", {22'd0, kif.keypad}, 32'h20);
    end
    tick();
    chk_idle_out("k5_rel");
    repeat (4) tick();

    // 3: bouncing digit 3 never accepted
    for (int i = 0; i < 10; i++) begin
      kif.key_raw = (i % 2 == 0) ? 10'b0000001000 : 10'd0;
      repeat (2) begin
        tick();
        chk("bounce_valid", {31'd0, kif.key_valid}, 32'd0);
        chk("bounce_keypad", {22'd0, kif.keypad}, 32'd0);
      end
    end
    kif.key_raw = 10'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bounce_tail_valid", {31'd0, kif.key_valid}, 32'd0);
      chk("bounce_tail_error", {31'd0, kif.key_error}, 32'd0);
    end

    // 4: chord 1+7 rejected, then digit 2 accepted
    kif.key_raw = 10'b0010000010;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (kif.key_error) pulses++;
      chk("chord_keypad", {22'd0, kif.keypad}, 32'd0);
      chk("chord_valid", {31'd0, kif.key_valid}, 32'd0);
      if (i == 6) chk("chord_err_edge6", {31'd0, kif.key_error}, 32'd1);
      else        chk("chord_err_other", {31'd0, kif.key_error}, 32'd0);
    end
    chk("chord_err_count", pulses, 32'd1);
    kif.key_raw = 10'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("chord_rel_error", {31'd0, kif.key_error}, 32'd0);
      chk("chord_rel_valid", {31'd0, kif.key_valid}, 32'd0);
    end
    kif.key_raw = 10'b0000000100;
    repeat (6) tick();
    chk("k2_valid", {31'd0, kif.key_valid}, 32'd1);
    chk("k2_code", {28'd0, kif.key_code}, 32'd2);
    chk("k2_keypad", {22'd0, kif.keypad}, 32'h4);
    kif.key_raw = 10'd0;
    repeat (10) tick();
    chk_idle_out("k2_rel");

    // 5: '#' press, then roll-over onto digit 4
    kif.sharp_raw = 1'b1;
    repeat (6) tick();
    chk("sh_valid", {31'd0, kif.key_valid}, 32'd1);
    chk("sh_sharp", {31'd0, kif.sharp}, 32'd1);
    chk("sh_code", {28'd0, kif.key_code}, 32'd10);
    chk("sh_keypad", {22'd0, kif.keypad}, 32'd0);
    repeat (4) tick();
    kif.key_raw = 10'b0000010000;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("roll_sharp", {31'd0, kif.sharp}, 32'd1);
      chk("roll_valid", {31'd0, kif.key_valid}, 32'd0);
      chk("roll_keypad", {22'd0, kif.keypad}, 32'd0);
      chk("roll_code", {28'd0, kif.key_code}, 32'd10);
    end
    kif.sharp_raw = 1'b0;
    kif.key_raw   = 10'd0;
    repeat (5) tick();
    chk("roll_rel_hold", {31'd0, kif.sharp}, 32'd1);
    tick();
    chk_idle_out("roll_rel");
    repeat (4) tick();

    // 6: digit 9 accepted, reset mid-hold, re-accepted afterwards
    kif.key_raw = 10'b1000000000;
    repeat (6) tick();
    chk("k9_valid", {31'd0, kif.key_valid}, 32'd1);
    chk("k9_code", {28'd0, kif.key_code}, 32'd9);
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk_idle_out("k9_async_rst");
    tick();
    reset = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("k9_re_early", {31'd0, kif.key_valid}, 32'd0);
    end
    tick();
    chk("k9_re_valid", {31'd0, kif.key_valid}, 32'd1);
    chk("k9_re_code", {28'd0, kif.key_code}, 32'd9);
    chk("k9_re_keypad", {22'd0, kif.keypad}, 32'h200);
    kif.key_raw = 10'd0;
    repeat (10) tick();
    chk_idle_out("k9_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
